// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal branch predictor with BTB, mispredict flagging and statistics
// Prediction reads the tables before any same-cycle training write (read-before-write).
module branch_predictor #(
   parameter int IDX_BITS = 6,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                fetch_valid,
   input  logic [31:0]         fetch_pc,
   output logic                pred_valid,
   output logic                pred_taken,
   output logic [31:0]         pred_target,
   input  logic                upd_valid,
   input  logic [31:0]         upd_pc,
   input  logic                upd_is_branch,
   input  logic [31:0]         upd_target,
   input  logic                upd_pred_taken,
   output logic                mispredict,
   output logic [31:0]         redirect_pc,
   output logic [CNT_BITS-1:0] br_count,
   output logic [CNT_BITS-1:0] miss_count
);
   localparam int DEPTH    = 1 << IDX_BITS;
   localparam int TAG_BITS = 30 - IDX_BITS;

   logic [DEPTH-1:0]               valid_q;
   logic [DEPTH-1:0][TAG_BITS-1:0] tag_q;
   logic [DEPTH-1:0][31:0]         target_q;
   logic [DEPTH-1:0][1:0]          ctr_q;

   logic [IDX_BITS-1:0] f_idx, u_idx;
   logic [TAG_BITS-1:0] f_tag, u_tag;
   logic                f_taken, u_hit, u_miss;
   logic                unused_pc_bits;

   assign f_idx   = fetch_pc[IDX_BITS+1:2];
   assign f_tag   = fetch_pc[31:IDX_BITS+2];
   assign u_idx   = upd_pc[IDX_BITS+1:2];
   assign u_tag   = upd_pc[31:IDX_BITS+2];
   assign f_taken = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && ctr_q[f_idx][1];
   assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_miss  = upd_valid && (upd_is_branch != upd_pred_taken);
   assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         tag_q       <= '0;
         target_q    <= '0;
         ctr_q       <= {DEPTH{2'b01}};
         pred_valid  <= 1'b0;
         pred_taken  <= 1'b0;
         pred_target <= '0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
         br_count    <= '0;
         miss_count  <= '0;
      end else begin
         pred_valid <= fetch_valid;
         if (fetch_valid) begin
            pred_taken  <= f_taken;
            pred_target <= f_taken ? target_q[f_idx] : fetch_pc + 32'd4;
         end

         mispredict <= u_miss;
         if (upd_valid) begin
            redirect_pc <= upd_is_branch ? upd_target : upd_pc + 32'd4;
            if (br_count != '1)
               br_count <= br_count + CNT_BITS'(1);
         end
         if (u_miss && miss_count != '1)
            miss_count <= miss_count + CNT_BITS'(1);

         // Training: saturating 2-bit counter on hit, allocate weakly-taken on taken miss
         if (upd_valid) begin
            if (u_hit) begin
               if (upd_is_branch) begin
                  target_q[u_idx] <= upd_target;
                  if (ctr_q[u_idx] != 2'b11)
                     ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
               end else if (ctr_q[u_idx] != 2'b00) begin
                  ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
               end
            end else if (upd_is_branch) begin
               valid_q[u_idx]  <= 1'b1;
               tag_q[u_idx]    <= u_tag;
               target_q[u_idx] <= upd_target;
               ctr_q[u_idx]    <= 2'b10;
            end
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
// Reference keeps the predictor tables as plain arrays and integer counters.
module tb_branch_predictor;
   localparam int IDX_BITS = 6;
   localparam int CNT_BITS = 8;
   localparam int DEPTH    = 1 << IDX_BITS;
   localparam int MAXC     = (1 << CNT_BITS) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                fetch_valid = 1'b0;
   logic [31:0]         fetch_pc = '0;
   logic                pred_valid, pred_taken, mispredict;
   logic [31:0]         pred_target, redirect_pc;
   logic                upd_valid = 1'b0, upd_is_branch = 1'b0, upd_pred_taken = 1'b0;
   logic [31:0]         upd_pc = '0, upd_target = '0;
   logic [CNT_BITS-1:0] br_count, miss_count;

   int n_cmp = 0;
   int n_fail = 0;

   bit          m_valid [DEPTH];
   int unsigned m_tag   [DEPTH];
   logic [31:0] m_target[DEPTH];
   int          m_ctr   [DEPTH];
   logic        e_pv, e_pt, e_mp;
   logic [31:0] e_ptg, e_rpc;
   int          e_br, e_miss;

   branch_predictor #(.IDX_BITS(IDX_BITS), .CNT_BITS(CNT_BITS)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .br_count(br_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      e_pv = 0; e_pt = 0; e_mp = 0; e_ptg = '0; e_rpc = '0; e_br = 0; e_miss = 0;
   endfunction

   // One clock: drive inputs, predict from pre-update model, train model, sample at edge+1
   task automatic cyc(input logic fv, input logic [31:0] fpc, input logic uv,
                      input logic [31:0] upc, input logic ub, input logic [31:0] ut,
                      input logic upt);
      int fi, ui;
      bit fhit, uhit;
      fetch_valid = fv; fetch_pc = fpc;
      upd_valid = uv; upd_pc = upc; upd_is_branch = ub; upd_target = ut; upd_pred_taken = upt;
      fi   = int'((fpc / 4) % DEPTH);
      ui   = int'((upc / 4) % DEPTH);
      fhit = m_valid[fi] && m_tag[fi] == (fpc >> (IDX_BITS + 2));
      uhit = m_valid[ui] && m_tag[ui] == (upc >> (IDX_BITS + 2));
      e_pv = fv;
      if (fv) begin
         e_pt  = fhit && m_ctr[fi] >= 2;
         e_ptg = e_pt ? m_target[fi] : fpc + 32'd4;
      end
      e_mp = uv && (ub != upt);
      if (uv) begin
         e_rpc = ub ? ut : upc + 32'd4;
         if (e_br < MAXC) e_br++;
         if (e_mp && e_miss < MAXC) e_miss++;
         if (uhit) begin
            if (ub) begin
               m_target[ui] = ut;
               if (m_ctr[ui] < 3) m_ctr[ui]++;
            end else if (m_ctr[ui] > 0) begin
               m_ctr[ui]--;
            end
         end else if (ub) begin
            m_valid[ui] = 1'b1; m_tag[ui] = upc >> (IDX_BITS + 2);
            m_target[ui] = ut;  m_ctr[ui] = 2;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fetch_valid = 1'b1; fetch_pc = 32'h100; upd_valid = 1'b1; upd_is_branch = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({pred_valid, pred_taken, mispredict} !== 3'b000) begin
         n_fail++; $display("FAIL reset_flags got %b want 000", {pred_valid, pred_taken, mispredict});
      end
      n_cmp++;
      if (pred_target !== 32'h0 || redirect_pc !== 32'h0) begin
         n_fail++; $display("FAIL reset_pcs got %h/%h want 0/0", pred_target, redirect_pc);
      end
      n_cmp++;
      if (br_count !== '0 || miss_count !== '0) begin
         n_fail++; $display("FAIL reset_counts got %0d/%0d want 0/0", br_count, miss_count);
      end
      rst_n = 1'b1;
      cyc(1, 32'h100, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         n_fail++; $display("FAIL first_fetch got v%b t%b %h want v1 t0 00000104", pred_valid, pred_taken, pred_target);
      end
   endtask

   task automatic test_train();
      cyc(0, 0, 1, 32'h100, 1, 32'h200, 0);
      n_cmp++;
      if (mispredict !== 1'b1 || redirect_pc !== 32'h200) begin
         n_fail++; $display("FAIL alloc_mispredict got %b %h want 1 00000200", mispredict, redirect_pc);
      end
      cyc(1, 32'h100, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
         n_fail++; $display("FAIL alloc_predict got %b %h want 1 00000200", pred_taken, pred_target);
      end
      n_cmp++;
      if (mispredict !== 1'b0) begin
         n_fail++; $display("FAIL mispredict_clear got %b want 0", mispredict);
      end
      repeat (3) cyc(0, 0, 1, 32'h100, 1, 32'h200, 1);
      cyc(0, 0, 1, 32'h100, 0, 32'h200, 1);
      n_cmp++;
      if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
         n_fail++; $display("FAIL nt_redirect got %b %h want 1 00000104", mispredict, redirect_pc);
      end
      cyc(1, 32'h100, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
         n_fail++; $display("FAIL hysteresis got %b %h want 1 00000200", pred_taken, pred_target);
      end
      cyc(0, 0, 1, 32'h100, 0, 32'h200, 1);
      cyc(1, 32'h100, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         n_fail++; $display("FAIL weak_nt got %b %h want 0 00000104", pred_taken, pred_target);
      end
   endtask

   task automatic test_alias();
      logic [31:0] alias_pc;
      alias_pc = 32'h100 + (32'd4 << IDX_BITS);
      cyc(1, alias_pc, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b0 || pred_target !== alias_pc + 32'd4) begin
         n_fail++; $display("FAIL alias_miss got %b %h want 0 %h", pred_taken, pred_target, alias_pc + 32'd4);
      end
      cyc(0, 0, 1, alias_pc, 1, 32'h500, 0);
      cyc(1, alias_pc, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h500) begin
         n_fail++; $display("FAIL alias_alloc got %b %h want 1 00000500", pred_taken, pred_target);
      end
      cyc(1, 32'h100, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         n_fail++; $display("FAIL alias_evicted got %b %h want 0 00000104", pred_taken, pred_target);
      end
   endtask

   task automatic test_same_cycle();
      cyc(1, 32'h300, 1, 32'h300, 1, 32'h800, 0);
      n_cmp++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
         n_fail++; $display("FAIL rbw_old got %b %h want 0 00000304", pred_taken, pred_target);
      end
      cyc(1, 32'h300, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h800) begin
         n_fail++; $display("FAIL rbw_new got %b %h want 1 00000800", pred_taken, pred_target);
      end
   endtask

   task automatic test_random();
      logic [31:0] pool[6];
      logic [31:0] fpc, upc;
      logic        fv, uv;
      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200;
      pool[3] = 32'h1100; pool[4] = 32'hFFFF_FFFC; pool[5] = 32'h300;
      for (int n = 0; n < 600; n++) begin
         fpc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 5)];
         upc = pool[$urandom_range(0, 5)];
         fv  = ($urandom_range(0, 3) != 0);
         uv  = ($urandom_range(0, 2) != 0);
         cyc(fv, fpc, uv, upc, 1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom));
         n_cmp++;
         if (pred_valid !== e_pv || pred_taken !== e_pt || pred_target !== e_ptg) begin
            n_fail++; $display("FAIL rnd_pred @%0d got v%b t%b %h want v%b t%b %h", n,
                               pred_valid, pred_taken, pred_target, e_pv, e_pt, e_ptg);
         end
         n_cmp++;
         if (mispredict !== e_mp || (uv && redirect_pc !== e_rpc)) begin
            n_fail++; $display("FAIL rnd_resolve @%0d got %b %h want %b %h", n, mispredict, redirect_pc, e_mp, e_rpc);
         end
         n_cmp++;
         if (int'(br_count) != e_br || int'(miss_count) != e_miss) begin
            n_fail++; $display("FAIL rnd_counts @%0d got %0d/%0d want %0d/%0d", n, br_count, miss_count, e_br, e_miss);
         end
      end
   endtask

   task automatic test_saturate_and_reset();
      rst_n = 1'b0; #1; rst_n = 1'b1;
      model_reset();
      repeat (MAXC) cyc(0, 0, 1, 32'h40, 0, 0, 1);
      n_cmp++;
      if (int'(br_count) != MAXC || int'(miss_count) != MAXC) begin
         n_fail++; $display("FAIL count_full got %0d/%0d want %0d/%0d", br_count, miss_count, MAXC, MAXC);
      end
      repeat (2) cyc(0, 0, 1, 32'h40, 0, 0, 1);
      n_cmp++;
      if (int'(br_count) != MAXC || int'(miss_count) != MAXC) begin
         n_fail++; $display("FAIL count_sat got %0d/%0d want %0d/%0d", br_count, miss_count, MAXC, MAXC);
      end
      cyc(0, 0, 1, 32'h100, 1, 32'h900, 0);
      fetch_valid = 1'b1; fetch_pc = 32'h100;
      upd_valid = 1'b1; upd_pc = 32'h100; upd_is_branch = 1'b1; upd_target = 32'hA00;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (br_count !== '0 || miss_count !== '0 || mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
         n_fail++; $display("FAIL async_reset got %0d/%0d %b %h want 0/0 0 0", br_count, miss_count, mispredict, redirect_pc);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      cyc(1, 32'h100, 0, 0, 0, 0, 0);
      n_cmp++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104 || pred_valid !== 1'b1) begin
         n_fail++; $display("FAIL table_cleared got v%b t%b %h want v1 t0 00000104", pred_valid, pred_taken, pred_target);
      end
   endtask

   initial begin
      test_reset();
      test_train();
      test_alias();
      test_same_cycle();
      test_random();
      test_saturate_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
